// File: rtl/load_store_buffer_pkg.sv
// Shared widths, opcodes, memory size encodings and FSM states for the load/store buffer.
package cpu_define;

    localparam int TagBus     = 4;
    localparam int OPBus      = 6;
    localparam int DataBus    = 32;
    localparam int AddressBus = 32;

    localparam logic               Valid   = 1'b1;
    localparam logic               Invalid = 1'b0;
    localparam logic [DataBus-1:0] Null    = '0;

    localparam logic [OPBus-1:0] OP_LB  = 6'd1;
    localparam logic [OPBus-1:0] OP_LH  = 6'd2;
    localparam logic [OPBus-1:0] OP_LW  = 6'd3;
    localparam logic [OPBus-1:0] OP_LBU = 6'd4;
    localparam logic [OPBus-1:0] OP_LHU = 6'd5;
    localparam logic [OPBus-1:0] OP_SB  = 6'd6;
    localparam logic [OPBus-1:0] OP_SH  = 6'd7;
    localparam logic [OPBus-1:0] OP_SW  = 6'd8;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_BCAST    = 2'd2
    } lsb_state_e;

endpackage

// File: rtl/load_store_buffer_extend.sv
// Opcode decode for the memory request (size, read/write) and load-result extension.
module lsb_load_extend
    import cpu_define::*;
#(
    parameter int OP_W   = OPBus,
    parameter int DATA_W = DataBus
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_raw,
    output logic [DATA_W-1:0] o_ext,
    output logic [1:0]        o_size,
    output logic              o_rw
);

    // Stores produce 0 on the CDB; unknown opcodes behave like LW.
    always_comb begin
        o_ext  = i_raw;
        o_size = MEM_SIZE_W;
        o_rw   = 1'b0;
        case (i_op)
            OP_LB:  begin o_ext = {{(DATA_W-8){i_raw[7]}}, i_raw[7:0]};   o_size = MEM_SIZE_B; end
            OP_LH:  begin o_ext = {{(DATA_W-16){i_raw[15]}}, i_raw[15:0]}; o_size = MEM_SIZE_H; end
            OP_LW:  begin o_ext = i_raw;                                    o_size = MEM_SIZE_W; end
            OP_LBU: begin o_ext = {{(DATA_W-8){1'b0}}, i_raw[7:0]};        o_size = MEM_SIZE_B; end
            OP_LHU: begin o_ext = {{(DATA_W-16){1'b0}}, i_raw[15:0]};      o_size = MEM_SIZE_H; end
            OP_SB:  begin o_ext = '0; o_size = MEM_SIZE_B; o_rw = 1'b1; end
            OP_SH:  begin o_ext = '0; o_size = MEM_SIZE_H; o_rw = 1'b1; end
            OP_SW:  begin o_ext = '0; o_size = MEM_SIZE_W; o_rw = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_buffer.sv
// Tag-indexed load/store buffer: captures ops from the RS, issues only the ROB head
// to memory, and broadcasts the result on the LSB CDB.
module load_store_buffer
    import cpu_define::*;
#(
    parameter int TAG_W  = TagBus,
    parameter int OP_W   = OPBus,
    parameter int DATA_W = DataBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              LSB_valid,
    input  logic [OP_W-1:0]   LSB_op,
    input  logic [DATA_W-1:0] LSB_reg1,
    input  logic [DATA_W-1:0] LSB_reg2,
    input  logic [DATA_W-1:0] LSB_imm,
    input  logic [TAG_W-1:0]  LSB_reg_des_rob,
    input  logic              rob_head_valid,
    input  logic [TAG_W-1:0]  rob_head_tag,
    output logic              mem_req_valid,
    output logic              mem_req_rw,
    output logic [DATA_W-1:0] mem_req_addr,
    output logic [1:0]        mem_req_size,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              LSB_cdb_valid,
    output logic [TAG_W-1:0]  LSB_cdb_tag,
    output logic [DATA_W-1:0] LSB_cdb_data
);

    localparam int DEPTH = 1 << TAG_W;

    logic [DEPTH-1:0]  r_slot_valid;
    logic [OP_W-1:0]   r_slot_op    [DEPTH];
    logic [DATA_W-1:0] r_slot_addr  [DEPTH];
    logic [DATA_W-1:0] r_slot_wdata [DEPTH];

    lsb_state_e        r_state;
    logic [TAG_W-1:0]  r_tag;
    logic [OP_W-1:0]   r_op;

    logic [OP_W-1:0]   w_dec_op;
    logic [DATA_W-1:0] w_ext;
    logic [1:0]        w_size;
    logic              w_rw;
    logic              w_issue;

    // One decoder serves both phases: head slot's op while idle, in-flight op otherwise.
    assign w_dec_op = (r_state == S_IDLE) ? r_slot_op[rob_head_tag] : r_op;
    assign w_issue  = rob_head_valid && r_slot_valid[rob_head_tag];

    lsb_load_extend #(.OP_W(OP_W), .DATA_W(DATA_W)) u_ext (
        .i_op   (w_dec_op),
        .i_raw  (mem_resp_data),
        .o_ext  (w_ext),
        .o_size (w_size),
        .o_rw   (w_rw)
    );

    // Slot payload; needs no reset since the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (rdy && !clear && !rst && LSB_valid) begin
            r_slot_op[LSB_reg_des_rob]    <= LSB_op;
            r_slot_addr[LSB_reg_des_rob]  <= LSB_reg1 + LSB_imm;
            r_slot_wdata[LSB_reg_des_rob] <= LSB_reg2;
        end
    end

    // Issue FSM plus slot valid bits; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || (rdy && clear)) begin
            r_slot_valid  <= '0;
            r_state       <= S_IDLE;
            r_tag         <= '0;
            r_op          <= '0;
            mem_req_valid <= Invalid;
            mem_req_rw    <= 1'b0;
            mem_req_addr  <= Null;
            mem_req_size  <= MEM_SIZE_B;
            mem_req_wdata <= Null;
            LSB_cdb_valid <= Invalid;
            LSB_cdb_tag   <= '0;
            LSB_cdb_data  <= Null;
        end else if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        mem_req_valid <= Valid;
                        mem_req_rw    <= w_rw;
                        mem_req_size  <= w_size;
                        mem_req_addr  <= r_slot_addr[rob_head_tag];
                        mem_req_wdata <= r_slot_wdata[rob_head_tag];
                        r_tag         <= rob_head_tag;
                        r_op          <= r_slot_op[rob_head_tag];
                        r_state       <= S_WAIT_MEM;
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_resp_valid) begin
                        mem_req_valid <= Invalid;
                        mem_req_rw    <= 1'b0;
                        mem_req_addr  <= Null;
                        mem_req_size  <= MEM_SIZE_B;
                        mem_req_wdata <= Null;
                        LSB_cdb_valid <= Valid;
                        LSB_cdb_tag   <= r_tag;
                        LSB_cdb_data  <= w_ext;
                        r_state       <= S_BCAST;
                    end
                end
                S_BCAST: begin
                    LSB_cdb_valid       <= Invalid;
                    LSB_cdb_tag         <= '0;
                    LSB_cdb_data        <= Null;
                    r_slot_valid[r_tag] <= Invalid;
                    r_state             <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            // Placed last so a capture wins over the BCAST free of the same slot.
            if (LSB_valid) r_slot_valid[LSB_reg_des_rob] <= Valid;
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed + randomized bench for load_store_buffer with a slot-level reference model.
module tb_load_store_buffer;
    import cpu_define::*;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        LSB_valid;
    logic [5:0]  LSB_op;
    logic [31:0] LSB_reg1, LSB_reg2, LSB_imm;
    logic [3:0]  LSB_reg_des_rob;
    logic        rob_head_valid;
    logic [3:0]  rob_head_tag;
    logic        mem_req_valid, mem_req_rw;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [1:0]  mem_req_size;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        LSB_cdb_valid;
    logic [3:0]  LSB_cdb_tag;
    logic [31:0] LSB_cdb_data;

    int checks = 0;
    int errors = 0;

    // Reference model: what each ROB tag's slot holds.
    logic        m_valid [16];
    logic [5:0]  m_op    [16];
    logic [31:0] m_addr  [16];
    logic [31:0] m_wdata [16];

    load_store_buffer #(.TAG_W(4), .OP_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .LSB_valid(LSB_valid), .LSB_op(LSB_op), .LSB_reg1(LSB_reg1), .LSB_reg2(LSB_reg2),
        .LSB_imm(LSB_imm), .LSB_reg_des_rob(LSB_reg_des_rob),
        .rob_head_valid(rob_head_valid), .rob_head_tag(rob_head_tag),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .LSB_cdb_valid(LSB_cdb_valid), .LSB_cdb_tag(LSB_cdb_tag), .LSB_cdb_data(LSB_cdb_data)
    );

    always #5 clk = ~clk;

    // A flush must never hit while an op is executing (request out or broadcasting).
    always @(posedge clk) begin
        if (clear && rdy && !rst) begin
            checks++;
            assert (!mem_req_valid && !LSB_cdb_valid) else begin
                errors++;
                $error("FAIL clear_while_busy observed req=%0b cdb=%0b expected 0/0", mem_req_valid, LSB_cdb_valid);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [5:0] op, input logic [31:0] d);
        case (op)
            OP_LB:  return 32'(d[7:0])  - (d[7]  ? 32'h100   : 32'h0);
            OP_LH:  return 32'(d[15:0]) - (d[15] ? 32'h10000 : 32'h0);
            OP_LBU: return 32'(d[7:0]);
            OP_LHU: return 32'(d[15:0]);
            OP_LW:  return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] exp_size(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 2'd0;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB || op == OP_SH || op == OP_SW);
    endfunction

    task automatic capture(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] imm, input logic [3:0] tag);
        LSB_valid = 1'b1; LSB_op = op; LSB_reg1 = r1; LSB_reg2 = r2; LSB_imm = imm;
        LSB_reg_des_rob = tag;
        tick();
        LSB_valid = 1'b0;
        m_valid[tag] = 1'b1; m_op[tag] = op; m_addr[tag] = r1 + imm; m_wdata[tag] = r2;
    endtask

    task automatic model_flush();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_cdb"}, 32'(LSB_cdb_valid), 32'd0);
    endtask

    // Make tag the ROB head, follow it through request, response and broadcast.
    task automatic exec_head(input logic [3:0] tag, input int delay, input logic [31:0] resp);
        int n;
        logic [31:0] a;
        rob_head_valid = 1'b1; rob_head_tag = tag;
        n = 0;
        while (!mem_req_valid && n < 30) begin tick(); n++; end
        chk("req_seen", 32'(mem_req_valid), 32'd1);
        chk("issue_lat", n, 1);
        chk("req_addr", mem_req_addr, m_addr[tag]);
        chk("req_rw", 32'(mem_req_rw), 32'(is_store(m_op[tag])));
        chk("req_size", 32'(mem_req_size), 32'(exp_size(m_op[tag])));
        chk("req_wdata", mem_req_wdata, m_wdata[tag]);
        a = mem_req_addr;
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("req_hold_v", 32'(mem_req_valid), 32'd1);
            chk("req_hold_a", mem_req_addr, a);
            chk("cdb_early", 32'(LSB_cdb_valid), 32'd0);
        end
        mem_resp_valid = 1'b1; mem_resp_data = resp;
        tick();
        mem_resp_valid = 1'b0; mem_resp_data = $urandom;
        chk("req_drop", 32'(mem_req_valid), 32'd0);
        chk("cdb_valid", 32'(LSB_cdb_valid), 32'd1);
        chk("cdb_tag", 32'(LSB_cdb_tag), 32'(tag));
        chk("cdb_data", LSB_cdb_data, exp_data(m_op[tag], resp));
        m_valid[tag] = 1'b0;
        tick();
        chk("cdb_pulse", 32'(LSB_cdb_valid), 32'd0);
        chk("cdb_tag0", 32'(LSB_cdb_tag), 32'd0);
        chk("cdb_data0", LSB_cdb_data, 32'd0);
        chk("no_reissue", 32'(mem_req_valid), 32'd0);
        rob_head_valid = 1'b0;
    endtask

    logic [5:0] ops [8];

    initial begin
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; LSB_valid = 1'b0; LSB_op = '0;
        LSB_reg1 = '0; LSB_reg2 = '0; LSB_imm = '0; LSB_reg_des_rob = '0;
        rob_head_valid = 1'b0; rob_head_tag = '0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        model_flush();
        tick(); tick();
        rst = 1'b0;
        chk("rst_req", 32'(mem_req_valid), 32'd0);
        chk("rst_addr", mem_req_addr, 32'd0);
        chk("rst_wdata", mem_req_wdata, 32'd0);
        chk("rst_cdb", 32'(LSB_cdb_valid), 32'd0);
        chk("rst_cdb_data", LSB_cdb_data, 32'd0);

        // LW basic
        capture(OP_LW, 32'h1000, 32'h0, 32'h8, 4'd3);
        chk("lw_addr_model", m_addr[3], 32'h1008);
        exec_head(4'd3, 0, 32'hDEADBEEF);

        // Sign vs zero extension
        capture(OP_LB, 32'h20, 32'h0, 32'h0, 4'd1);
        exec_head(4'd1, 1, 32'h00000080);
        capture(OP_LBU, 32'h20, 32'h0, 32'h0, 4'd2);
        exec_head(4'd2, 0, 32'h00000080);
        capture(OP_LH, 32'h40, 32'h0, 32'h2, 4'd4);
        exec_head(4'd4, 2, 32'h00008001);

        // Store waits behind a different head
        capture(OP_SH, 32'h100, 32'h12345678, 32'hFFFFFFFE, 4'd5);
        rob_head_valid = 1'b1; rob_head_tag = 4'd4;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("not_head", 32'(mem_req_valid), 32'd0);
        end
        exec_head(4'd5, 0, 32'hCAFEF00D);

        // Back-to-back captures, issued in head order with a slow memory
        capture(OP_LW, 32'h200, 32'h0, 32'h4, 4'd7);
        capture(OP_LHU, 32'h300, 32'h0, 32'h6, 4'd6);
        exec_head(4'd6, 5, 32'h0000F00F);
        exec_head(4'd7, 5, 32'h11223344);

        // Capture into the slot the head already points at
        rob_head_valid = 1'b1; rob_head_tag = 4'd11;
        capture(OP_SW, 32'h400, 32'hA5A5A5A5, 32'h10, 4'd11);
        chk("same_cycle_no_issue", 32'(mem_req_valid), 32'd0);
        exec_head(4'd11, 0, 32'h0);

        // Flush in IDLE empties every slot
        capture(OP_LW, 32'h500, 32'h0, 32'h0, 4'd1);
        capture(OP_SB, 32'h600, 32'h77, 32'h0, 4'd2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_flush();
        check_quiet("clear");
        rob_head_valid = 1'b1; rob_head_tag = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("flushed_1", 32'(mem_req_valid), 32'd0);
        end
        rob_head_tag = 4'd2;
        tick();
        chk("flushed_2", 32'(mem_req_valid), 32'd0);
        rob_head_valid = 1'b0;

        // rdy low freezes WAIT_MEM; reset then aborts it
        capture(OP_LW, 32'h700, 32'h0, 32'h0, 4'd9);
        capture(OP_LB, 32'h800, 32'h0, 32'h0, 4'd10);
        rob_head_valid = 1'b1; rob_head_tag = 4'd9;
        tick();
        chk("w_req", 32'(mem_req_valid), 32'd1);
        rdy = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h99;
        tick();
        mem_resp_valid = 1'b0;
        chk("stall_req", 32'(mem_req_valid), 32'd1);
        chk("stall_addr", mem_req_addr, 32'h700);
        chk("stall_cdb", 32'(LSB_cdb_valid), 32'd0);
        rdy = 1'b1;
        tick();
        chk("resume_req", 32'(mem_req_valid), 32'd1);
        chk("resume_cdb", 32'(LSB_cdb_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_flush();
        check_quiet("rst_wait");
        chk("rst_addr2", mem_req_addr, 32'd0);
        for (int t = 9; t <= 10; t++) begin
            rob_head_valid = 1'b1; rob_head_tag = 4'(t);
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("rst_slots", 32'(mem_req_valid), 32'd0);
            end
        end
        rob_head_valid = 1'b0;
        tick();

        // Randomized pairs of ops, executed oldest first
        for (int it = 0; it < 40; it++) begin
            logic [3:0] t0, t1;
            t0 = 4'($urandom_range(0, 15));
            t1 = t0 ^ 4'($urandom_range(1, 15));
            capture(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom, t0);
            if (it % 2 == 0) capture(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom, t1);
            exec_head(t0, $urandom_range(0, 4), $urandom);
            if (it % 2 == 0) exec_head(t1, $urandom_range(0, 4), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
